// File: rtl/lenet_maxpool2x2.sv
// lenet_maxpool2x2: streaming 2x2 / stride-2 max-pool stage fed by a
// convolution layer's raster-order pixel write stream. One row of partial
// maxima is kept; a pooled pixel is emitted on every odd-row / odd-column
// input pixel, with dout_last marking the final pooled pixel of a map.
//
// Optional build macro: LENET_MAXPOOL_RELU_EN -- when defined, negative
// pooled results are clamped to zero (ReLU fused into the pool stage).
module lenet_maxpool2x2 #(
    parameter int DATA_WIDTH = 16,
    parameter int IMG_WIDTH  = 28,
    parameter int IMG_HEIGHT = 28
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wen,
    input  logic [DATA_WIDTH-1:0] din,
    output logic                  dout_valid,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  dout_last,
    output logic                  busy
);

    localparam int COL_W    = $clog2(IMG_WIDTH);
    localparam int ROW_W    = $clog2(IMG_HEIGHT);
    localparam int LB_DEPTH = IMG_WIDTH / 2;
    localparam int LB_W     = (LB_DEPTH > 1) ? $clog2(LB_DEPTH) : 1;

    logic [COL_W-1:0] col;
    logic [ROW_W-1:0] row;
    logic signed [DATA_WIDTH-1:0] hold;

    // One partial maximum per window column, produced on even rows.
    logic signed [DATA_WIDTH-1:0] linebuf [LB_DEPTH];

    logic [LB_W-1:0]              lb_idx;
    logic                         col_last;
    logic                         row_last;
    logic                         odd_col;
    logic                         odd_row;
    logic signed [DATA_WIDTH-1:0] pix;
    logic signed [DATA_WIDTH-1:0] lb_rd;
    logic signed [DATA_WIDTH-1:0] pair_max;
    logic signed [DATA_WIDTH-1:0] win_max;
    logic signed [DATA_WIDTH-1:0] result;

    // Window position decode and signed max tree for the current pixel.
    // NOTE: every combinational output gets a default first so no path
    // through the block leaves it unassigned (which would infer a latch).
    always_comb begin
        pix      = '0;
        lb_idx   = '0;
        lb_rd    = '0;
        pair_max = '0;
        win_max  = '0;
        result   = '0;

        col_last = (col == COL_W'(IMG_WIDTH - 1));
        row_last = (row == ROW_W'(IMG_HEIGHT - 1));
        odd_col  = col[0];
        odd_row  = row[0];

        pix      = $signed(din);
        lb_idx   = LB_W'(col >> 1);
        lb_rd    = linebuf[lb_idx];
        pair_max = (pix > hold) ? pix : hold;
        win_max  = (lb_rd > pair_max) ? lb_rd : pair_max;

`ifdef LENET_MAXPOOL_RELU_EN
        result   = win_max[DATA_WIDTH-1] ? '0 : win_max;
`else
        result   = win_max;
`endif
    end

    // Line buffer write: pair maximum of each even-row window column.
    // NOTE: the line buffer has no reset; each entry is always written on an
    // even row before the following odd row reads it, so stale data is never
    // observed and the array can map onto plain RAM.
    always_ff @(posedge clk) begin
        if (!rst && wen && !odd_row && odd_col) begin
            linebuf[lb_idx] <= pair_max;
        end
    end

    // Raster counters, pair register, busy flag and registered output.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            col        <= '0;
            row        <= '0;
            hold       <= '0;
            busy       <= 1'b0;
            dout_valid <= 1'b0;
            dout       <= '0;
            dout_last  <= 1'b0;
        end else begin
            dout_valid <= 1'b0;
            dout_last  <= 1'b0;
            if (wen) begin
                if (!odd_col) begin
                    hold <= pix;
                end

                if (col_last) begin
                    col <= '0;
                    row <= row_last ? '0 : row + 1'b1;
                end else begin
                    col <= col + 1'b1;
                end

                busy <= !(col_last && row_last);

                if (odd_row && odd_col) begin
                    dout_valid <= 1'b1;
                    dout       <= result;
                    dout_last  <= col_last && row_last;
                end
            end
        end
    end

endmodule
